// File: rtl/spi_match_engine_if.sv
// ---------------------------------------------------------------------------
// spi_match_engine_if: chip-select, byte bus and result outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_match_engine_if;
  logic       cs;
  logic [7:0] mosi;
  logic [7:0] miso;
  logic [7:0] result;
  logic       match;

  modport slave (input cs, mosi, output miso, result, match);
  modport master(output cs, mosi, input miso, result, match);
endinterface

`default_nettype wire

// File: rtl/spi_match_engine.sv
// ---------------------------------------------------------------------------
// spi_match_engine: SPI register file with a streaming char/mask matcher. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_match_engine #(
  parameter int NUM_SLOTS = 8,
  parameter int CNT_W     = 8
) (
  input  wire logic          sclk,
  input  wire logic          rst_n,
  spi_match_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    WR_ADDR = 3'd2,
    WR_DATA = 3'd3,
    STREAM  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // Mask slots 13..15 would alias the read-only status/count/result addresses
  localparam int MASK_ADDR_SLOTS = 13;

  state_t           state_q, state_d;
  logic [4:0]       addr_q;
  logic [7:0]       char_q [NUM_SLOTS];
  logic [7:0]       mask_q [NUM_SLOTS];
  logic [7:0]       result_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       miso_q;
  logic             match_q;

  logic             rd_en, wr_addr_ld, wr_en, stream_en, clr_en;
  logic [7:0]       hit_or;
  logic             any_hit;
  logic [7:0]       rd_data;
  logic [7:0]       count_ext;
  logic             count_sat;
  logic [4:0]       raddr;

  assign count_sat = (count_q == CNT_MAX);
  assign raddr     = bus.mosi[4:0];

  always_comb begin
    count_ext = 8'h00;
    count_ext[CNT_W-1:0] = count_q;
  end

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    wr_addr_ld = 1'b0;
    wr_en      = 1'b0;
    stream_en  = 1'b0;
    clr_en     = 1'b0;
    if (bus.cs) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          case (bus.mosi)
            8'h03:   state_d = RD_ADDR;
            8'h02:   state_d = WR_ADDR;
            8'h80:   state_d = STREAM;
            8'h81:   clr_en  = 1'b1;
            default: state_d = IDLE;
          endcase
        end
        RD_ADDR: begin
          rd_en   = 1'b1;
          state_d = IDLE;
        end
        WR_ADDR: begin
          wr_addr_ld = 1'b1;
          state_d    = WR_DATA;
        end
        WR_DATA: wr_en     = 1'b1;
        STREAM:  stream_en = 1'b1;
        default: state_d   = IDLE;
      endcase
    end
  end

  always_comb begin
    hit_or  = 8'h00;
    any_hit = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if ((mask_q[k] != 8'h00) && (bus.mosi == char_q[k])) begin
        hit_or  = hit_or | mask_q[k];
        any_hit = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (raddr == 5'(k)) rd_data = char_q[k];
      if ((k < MASK_ADDR_SLOTS) && (raddr == 5'(16 + k))) rd_data = mask_q[k];
    end
    case (raddr)
      5'h1D:   rd_data = {6'b0, count_sat, (result_q != 8'h00)};
      5'h1E:   rd_data = count_ext;
      5'h1F:   rd_data = result_q;
      default: ;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 5'd0;
      result_q <= 8'h00;
      count_q  <= '0;
      miso_q   <= 8'h00;
      match_q  <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        char_q[k] <= 8'h00;
        mask_q[k] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      match_q <= stream_en & any_hit;
      if (rd_en) miso_q <= rd_data;
      if (wr_addr_ld) addr_q <= bus.mosi[4:0];
      if (wr_en) begin
        addr_q <= addr_q + 5'd1;
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (addr_q == 5'(k)) char_q[k] <= bus.mosi;
          if ((k < MASK_ADDR_SLOTS) && (addr_q == 5'(16 + k))) mask_q[k] <= bus.mosi;
        end
      end
      if (clr_en) begin
        result_q <= 8'h00;
        count_q  <= '0;
      end
      if (stream_en) begin
        result_q <= result_q | hit_or;
        if (any_hit && !count_sat) count_q <= count_q + CNT_ONE;
      end
    end
  end

  assign bus.miso   = miso_q;
  assign bus.result = result_q;
  assign bus.match  = match_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_match_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_match_engine: two configurations against a behavioural model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_match_engine;

  logic sclk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   chk_en   = 1'b0;

  always #5 sclk = ~sclk;

  spi_match_engine_if bus0();
  spi_match_engine_if bus1();

  spi_match_engine dut0 (.sclk(sclk), .rst_n(rst_n), .bus(bus0));
  spi_match_engine #(.NUM_SLOTS(4), .CNT_W(2)) dut1 (.sclk(sclk), .rst_n(rst_n), .bus(bus1));

  // Reference: per-instance register file and transaction mode
  localparam int M_IDLE = 0, M_RD = 1, M_WA = 2, M_WD = 3, M_ST = 4;
  int         ns   [2] = '{8, 4};
  int         cmax [2] = '{255, 3};
  logic [7:0] m_char [2][16];
  logic [7:0] m_mask [2][16];
  logic [7:0] m_res  [2];
  logic [7:0] m_miso [2];
  int         m_cnt  [2];
  logic       m_match[2];
  int         m_mode [2];
  int         m_addr [2];

  function automatic logic [7:0] m_read(int i, int a);
    if (a < 16) return (a < ns[i]) ? m_char[i][a] : 8'h00;
    if (a <= 28) return ((a - 16) < ns[i]) ? m_mask[i][a-16] : 8'h00;
    if (a == 29) return {6'b0, (m_cnt[i] == cmax[i]), (m_res[i] != 8'h00)};
    if (a == 30) return 8'(m_cnt[i]);
    return m_res[i];
  endfunction

  task automatic model_step();
    logic [7:0] b, orm;
    bit hit;
    b = bus0.mosi;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < 16; k++) begin
          m_char[i][k] = 8'h00;
          m_mask[i][k] = 8'h00;
        end
        m_res[i] = 0; m_cnt[i] = 0; m_miso[i] = 0; m_match[i] = 0;
        m_mode[i] = M_IDLE; m_addr[i] = 0;
      end else if (bus0.cs) begin
        m_mode[i]  = M_IDLE;
        m_match[i] = 1'b0;
      end else begin
        m_match[i] = 1'b0;
        case (m_mode[i])
          M_IDLE: begin
            if (b == 8'h03) m_mode[i] = M_RD;
            else if (b == 8'h02) m_mode[i] = M_WA;
            else if (b == 8'h80) m_mode[i] = M_ST;
            else if (b == 8'h81) begin m_res[i] = 0; m_cnt[i] = 0; end
          end
          M_RD: begin
            m_miso[i] = m_read(i, int'(b % 32));
            m_mode[i] = M_IDLE;
          end
          M_WA: begin
            m_addr[i] = int'(b % 32);
            m_mode[i] = M_WD;
          end
          M_WD: begin
            if (m_addr[i] < 16 && m_addr[i] < ns[i]) m_char[i][m_addr[i]] = b;
            else if (m_addr[i] >= 16 && m_addr[i] <= 28 && (m_addr[i] - 16) < ns[i])
              m_mask[i][m_addr[i]-16] = b;
            m_addr[i] = (m_addr[i] + 1) % 32;
          end
          default: begin
            orm = 0; hit = 0;
            for (int k = 0; k < ns[i]; k++)
              if (m_mask[i][k] != 0 && m_char[i][k] == b) begin
                orm |= m_mask[i][k];
                hit = 1;
              end
            m_res[i] |= orm;
            if (hit) begin
              if (m_cnt[i] < cmax[i]) m_cnt[i]++;
              m_match[i] = 1'b1;
            end
          end
        endcase
      end
    end
  endtask

  always @(posedge sclk) model_step();

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge sclk) begin
    if (chk_en) begin
      chk("miso0",   bus0.miso,         m_miso[0]);
      chk("result0", bus0.result,       m_res[0]);
      chk("match0",  {7'b0, bus0.match}, {7'b0, m_match[0]});
      chk("miso1",   bus1.miso,         m_miso[1]);
      chk("result1", bus1.result,       m_res[1]);
      chk("match1",  {7'b0, bus1.match}, {7'b0, m_match[1]});
    end
  end

  task automatic put(input logic c, input logic [7:0] b);
    bus0.cs = c; bus0.mosi = b;
    bus1.cs = c; bus1.mosi = b;
    @(negedge sclk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v0, output logic [7:0] v1);
    put(1'b0, 8'h03);
    put(1'b0, a);
    v0 = bus0.miso;
    v1 = bus1.miso;
    put(1'b1, 8'h00);
  endtask

  task automatic rd_lit(string nm, input logic [7:0] a, input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] v0, v1;
    rd(a, v0, v1);
    chk({nm, "_d0"}, v0, e0);
    chk({nm, "_d1"}, v1, e1);
  endtask

  task automatic burst(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1);
    put(1'b0, 8'h02); put(1'b0, a); put(1'b0, d0); put(1'b0, d1); put(1'b1, 8'h00);
  endtask

  function automatic logic [7:0] rnd_data();
    int s = $urandom_range(0, 7);
    if (s == 0) return 8'h00;
    if (s <= 5) return 8'h40 + 8'($urandom_range(0, 3));
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0] v0, v1;
    rst_n = 1'b0;
    put(1'b1, 8'h00);
    put(1'b1, 8'h00);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_result", bus0.result, 8'h00);
    chk("rst_match",  {7'b0, bus0.match}, 8'h00);
    chk("rst_miso",   bus1.miso, 8'h00);

    rd_lit("rd_1F_reset", 8'h1F, 8'h00, 8'h00);
    rd_lit("rd_1D_reset", 8'h1D, 8'h00, 8'h00);

    burst(8'h00, 8'h41, 8'h42);
    burst(8'h10, 8'h01, 8'h02);
    rd_lit("rd_char0", 8'h00, 8'h41, 8'h41);
    rd_lit("rd_char1", 8'h01, 8'h42, 8'h42);
    rd_lit("rd_mask0", 8'h10, 8'h01, 8'h01);
    rd_lit("rd_mask1", 8'h11, 8'h02, 8'h02);

    put(1'b0, 8'h80);
    put(1'b0, 8'h41);
    chk("st41_res", bus0.result, 8'h01);
    chk("st41_match", {7'b0, bus0.match}, 8'h01);
    put(1'b0, 8'h43);
    chk("st43_res", bus0.result, 8'h01);
    chk("st43_match", {7'b0, bus0.match}, 8'h00);
    put(1'b0, 8'h42);
    chk("st42_res", bus0.result, 8'h03);
    chk("st42_match", {7'b0, bus0.match}, 8'h01);
    put(1'b1, 8'h00);
    rd_lit("cnt_two", 8'h1E, 8'h02, 8'h02);

    burst(8'h02, 8'h55, 8'h55);
    burst(8'h12, 8'h10, 8'h20);
    put(1'b0, 8'h80);
    put(1'b0, 8'h55);
    chk("dual_hit_res", bus0.result, 8'h33);
    put(1'b1, 8'h00);
    rd_lit("cnt_dual", 8'h1E, 8'h03, 8'h03);

    put(1'b0, 8'h80);
    for (int n = 0; n < 4; n++) put(1'b0, 8'h41);
    put(1'b1, 8'h00);
    rd_lit("cnt_sat", 8'h1E, 8'h07, 8'h03);
    rd_lit("status_sat", 8'h1D, 8'h01, 8'h03);
    put(1'b0, 8'h81);
    put(1'b1, 8'h00);
    rd_lit("cnt_clr", 8'h1E, 8'h00, 8'h00);
    rd_lit("res_clr", 8'h1F, 8'h00, 8'h00);

    put(1'b0, 8'h02); put(1'b0, 8'h1F);
    put(1'b0, 8'h77); put(1'b0, 8'h88); put(1'b0, 8'h99);
    put(1'b1, 8'h00);
    rd_lit("wrap_s0", 8'h00, 8'h88, 8'h88);
    rd_lit("wrap_s1", 8'h01, 8'h99, 8'h99);
    rd_lit("wrap_1F", 8'h1F, 8'h00, 8'h00);

    put(1'b0, 8'h80);
    put(1'b0, 8'h88);
    rst_n = 1'b0;
    put(1'b0, 8'h88);
    rst_n = 1'b1;
    put(1'b0, 8'h03);
    put(1'b0, 8'h00);
    chk("postrst_rd0", bus0.miso, 8'h00);
    put(1'b1, 8'h00);
    rd_lit("postrst_01", 8'h01, 8'h00, 8'h00);
    rd_lit("postrst_10", 8'h10, 8'h00, 8'h00);
    rd_lit("postrst_1E", 8'h1E, 8'h00, 8'h00);

    for (int it = 0; it < 1500; it++) begin
      int op = $urandom_range(0, 9);
      if (op <= 2) begin
        put(1'b0, 8'h02);
        put(1'b0, ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom));
        for (int n = 0; n < int'($urandom_range(1, 4)); n++) put(1'b0, rnd_data());
      end else if (op <= 4) begin
        rd(8'($urandom), v0, v1);
      end else if (op <= 7) begin
        put(1'b0, 8'h80);
        for (int n = 0; n < int'($urandom_range(1, 8)); n++) begin
          if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
          put(1'b0, rnd_data());
          rst_n = 1'b1;
        end
      end else if (op == 8) begin
        put(1'b0, 8'h81);
      end else begin
        put(1'b0, 8'($urandom));
        put(1'b0, 8'($urandom));
      end
      put(1'b1, 8'h00);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
